// File: rtl/subtractor_pkg.sv
// Shared definitions for the multi-precision subtractor slice.
// Holds the sequencer state encoding, the default slice geometry shared with
// the parallel subtractor, and the signed-overflow rule for the full-width
// result.
package subtractor_pkg;

    // Default slice width and slice count.
    localparam int SIZE_DEFAULT  = 4;
    localparam int WORDS_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Signed overflow of a - b: the operands differ in sign and the result
    // sign differs from the minuend sign.
    function automatic logic calc_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic d_msb);
        return (a_msb ^ b_msb) & (a_msb ^ d_msb);
    endfunction

endpackage

// File: rtl/signed_four_bit_subtractor.sv
// SIZE-bit ripple-borrow parallel subtractor (purely combinational).
// Ports:
//   a, b  : SIZE-bit minuend / subtrahend slice
//   bin   : borrow into bit 0
//   diff  : a - b - bin modulo 2^SIZE
//   bout  : borrow out of the MSB
module signed_four_bit_subtractor
    import subtractor_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            bin,
    output logic [SIZE-1:0] diff,
    output logic            bout
);

    logic borrow_chain;

    always_comb begin
        diff         = '0;
        borrow_chain = bin;
        for (int i = 0; i < SIZE; i++) begin
            diff[i]      = a[i] ^ b[i] ^ borrow_chain;
            // Borrow when a<b at this bit, or equal bits with an incoming borrow.
            borrow_chain = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow_chain);
        end
        bout = borrow_chain;
    end

endmodule

// File: rtl/multiword_subtract_sequencer.sv
// Multi-precision subtractor front end. Captures a W-bit operand pair plus
// borrow-in, then walks the SIZE-bit slice subtractor across WORDS slices,
// LSB slice first, carrying the borrow between slices in a register. The
// result (difference, final borrow, signed overflow) is held until taken.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised, holds its payload until that edge.
// in_ready is high only in IDLE and never while rst is high. out_valid is high
// only in DONE, with diff/bout/ovf stable for the whole time it is high.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake carrying a, b, bin
//   out_valid/out_ready : result handshake carrying diff, bout, ovf
//   busy                : high in RUN or DONE
//   state_dbg           : current FSM state
//   borrow_dbg          : inter-slice borrow register
module multiword_subtract_sequencer
    import subtractor_pkg::*;
#(
    parameter  int SIZE  = SIZE_DEFAULT,
    parameter  int WORDS = WORDS_DEFAULT,
    localparam int W     = SIZE * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic         busy,
    output state_e       state_dbg,
    output logic         borrow_dbg
);

    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e           state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [W-1:0]     a_q,      a_d;
    logic [W-1:0]     b_q,      b_d;
    logic             borrow_q, borrow_d;
    logic [W-1:0]     diff_q,   diff_d;
    logic             bout_q,   bout_d;
    logic             ovf_q,    ovf_d;

    logic [SIZE-1:0]  slice_a;
    logic [SIZE-1:0]  slice_b;
    logic [SIZE-1:0]  slice_diff;
    logic             slice_bout;

    assign slice_a = a_q[idx_q*SIZE +: SIZE];
    assign slice_b = b_q[idx_q*SIZE +: SIZE];

    signed_four_bit_subtractor #(.SIZE(SIZE)) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .bin  (borrow_q),
        .diff (slice_diff),
        .bout (slice_bout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    idx_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                diff_d[idx_q*SIZE +: SIZE] = slice_diff;
                borrow_d = slice_bout;
                if (idx_q == LAST_IDX) begin
                    // The MSB slice result is being written now, so the
                    // overflow uses the fresh slice MSB rather than diff_q.
                    bout_d  = slice_bout;
                    ovf_d   = calc_ovf(a_q[W-1], b_q[W-1], slice_diff[SIZE-1]);
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Status outputs decode directly from the state register.
    assign in_ready   = (state_q == S_IDLE) && !rst;
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign diff       = diff_q;
    assign bout       = bout_q;
    assign ovf        = ovf_q;
    assign state_dbg  = state_q;
    assign borrow_dbg = borrow_q;

endmodule
